// File: rtl/clock_pkg.sv
// Shared encodings for the clock-step controller: operating modes and FSM states.
package clock_pkg;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BURST = 2'd3
  } state_e;

endpackage

// File: rtl/clock_div_channel.sv
// One clock-enable channel: divides the master advance enable by (div+1).
// The divisor is latched only at wrap so a period in flight always completes.
module clock_div_channel
  import clock_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;

  assign ce = advance && (cnt_q == div_lat_q);

  always_comb begin
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    if (ce) begin
      cnt_d     = '0;
      div_lat_d = div;
    end else if (advance) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      div_lat_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
    end
  end

endmodule

// File: rtl/clock_step_ctrl.sv
// Clock-step controller: HALT/RUN/STEP/BURST master enable, per-channel divided
// enables and a running count of advance cycles.
module clock_step_ctrl
  import clock_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 8,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    step_req,
  input  logic [BURST_W-1:0]      burst_len,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic                    advance,
  output logic [NUM_CH-1:0]       ce_o,
  output logic                    busy,
  output logic [CNT_W-1:0]        cyc_cnt
);

  state_e             state_q, state_d;
  logic               step_prev_q, step_prev_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic               trig;

  assign trig        = step_req && !step_prev_q;
  assign step_prev_d = step_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_prev_q <= 1'b0;
      remaining_q <= '0;
      cyc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_prev_q <= step_prev_d;
      remaining_q <= remaining_d;
      cyc_cnt_q   <= cyc_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (mode == MODE_RUN) begin
          state_d = RUN;
        end else if (mode == MODE_STEP && trig) begin
          state_d = STEP;
        end else if (mode == MODE_BURST && trig && burst_len != '0) begin
          state_d     = BURST;
          remaining_d = burst_len;
        end
      end
      RUN:  if (mode != MODE_RUN) state_d = IDLE;
      STEP: state_d = IDLE;
      // Only HALT may cut a burst short; other mode changes wait for it to finish.
      BURST: begin
        if (remaining_q == BURST_W'(1) || mode == MODE_HALT) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else begin
          remaining_d = remaining_q - BURST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    advance   = (state_q != IDLE);
    busy      = (state_q == STEP) || (state_q == BURST);
    cyc_cnt_d = cyc_cnt_q + CNT_W'(advance);
  end

  assign cyc_cnt = cyc_cnt_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_div_channel #(.DIV_W(DIV_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .div     (div_i[g*DIV_W +: DIV_W]),
      .ce      (ce_o[g])
    );
  end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl: fixed vector table, then model-scoreboarded sequences.
module tb_clock_step_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        step_req = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic [15:0] div_i = 16'd0;
  logic        advance;
  logic [1:0]  ce_o;
  logic        busy;
  logic [31:0] cyc_cnt;

  int errors = 0;
  int checks = 0;

  clock_step_ctrl #(.NUM_CH(2), .DIV_W(8), .BURST_W(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .mode(mode), .step_req(step_req),
    .burst_len(burst_len), .div_i(div_i), .advance(advance),
    .ce_o(ce_o), .busy(busy), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        adv;
    logic        busy;
    logic [1:0]  ce;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int          m_state = 0;
  logic        m_prev = 1'b0;
  logic [7:0]  m_rem = 8'd0;
  logic [31:0] m_cyc = 32'd0;
  logic [7:0]  m_cnt[2] = '{8'd0, 8'd0};
  logic [7:0]  m_lat[2] = '{8'd0, 8'd0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic       adv;
    logic [1:0] ce;
    logic       trig;
    exp_t       e;
    adv = (m_state != 0);
    for (int c = 0; c < 2; c++) ce[c] = adv && (m_cnt[c] == m_lat[c]);
    if (reset) begin
      m_state = 0; m_prev = 1'b0; m_rem = 8'd0; m_cyc = 32'd0;
      for (int c = 0; c < 2; c++) begin m_cnt[c] = 8'd0; m_lat[c] = 8'd0; end
    end else begin
      m_cyc = m_cyc + 32'(adv);
      for (int c = 0; c < 2; c++) begin
        if (ce[c]) begin m_cnt[c] = 8'd0; m_lat[c] = div_i[c*8 +: 8]; end
        else if (adv) m_cnt[c] = m_cnt[c] + 8'd1;
      end
      trig = step_req && !m_prev;
      m_prev = step_req;
      case (m_state)
        0: begin
          if (mode == 2'b01) m_state = 1;
          else if (mode == 2'b10 && trig) m_state = 2;
          else if (mode == 2'b11 && trig && burst_len != 8'd0) begin
            m_state = 3; m_rem = burst_len;
          end
        end
        1: if (mode != 2'b01) m_state = 0;
        2: m_state = 0;
        default: begin
          if (m_rem == 8'd1 || mode == 2'b00) begin m_state = 0; m_rem = 8'd0; end
          else m_rem = m_rem - 8'd1;
        end
      endcase
    end
    e.adv  = (m_state != 0);
    e.busy = (m_state == 2) || (m_state == 3);
    for (int c = 0; c < 2; c++) e.ce[c] = e.adv && (m_cnt[c] == m_lat[c]);
    e.cyc  = m_cyc;
    sb.push_back(e);
  endtask

  // One clock: model consumes the inputs sampled at this edge, DUT checked #1 later.
  task automatic tick();
    exp_t e;
    exp_t a;
    @(posedge clk);
    model_step();
    #1;
    e = sb.pop_front();
    a = '{adv: advance, busy: busy, ce: ce_o, cyc: cyc_cnt};
    chk("scoreboard", 64'(a), 64'(e));
  endtask

  task automatic do_reset();
    reset = 1'b1; step_req = 1'b0; mode = 2'b00;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  mode;
    logic        step;
    logic [7:0]  bl;
    logic        adv;
    logic        busy;
    logic [31:0] cyc;
  } vec_t;

  vec_t vt[13];
  int   n_adv, n_busy, n_ce0, n_ce1;
  logic [31:0] cyc0;
  logic [15:0] mask;

  initial begin
    vt[0]  = '{1'b1, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0};
    vt[1]  = '{1'b0, 2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0};
    vt[2]  = '{1'b0, 2'b10, 1'b1, 8'd0, 1'b1, 1'b1, 32'd0};
    vt[3]  = '{1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1'b0, 32'd1};
    vt[4]  = '{1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1'b0, 32'd1};
    vt[5]  = '{1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1'b0, 32'd1};
    vt[6]  = '{1'b0, 2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 32'd1};
    vt[7]  = '{1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1'b0, 32'd1};
    vt[8]  = '{1'b0, 2'b11, 1'b0, 8'd0, 1'b0, 1'b0, 32'd1};
    vt[9]  = '{1'b0, 2'b11, 1'b1, 8'd2, 1'b1, 1'b1, 32'd1};
    vt[10] = '{1'b0, 2'b11, 1'b0, 8'd2, 1'b1, 1'b1, 32'd2};
    vt[11] = '{1'b0, 2'b11, 1'b0, 8'd2, 1'b0, 1'b0, 32'd3};
    vt[12] = '{1'b0, 2'b00, 1'b0, 8'd2, 1'b0, 1'b0, 32'd3};

    #1;
    for (int i = 0; i < 13; i++) begin
      reset = vt[i].rst; mode = vt[i].mode; step_req = vt[i].step; burst_len = vt[i].bl;
      tick();
      chk($sformatf("vec%0d_adv", i), 64'(advance), 64'(vt[i].adv));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].busy));
      chk($sformatf("vec%0d_cyc", i), 64'(cyc_cnt), 64'(vt[i].cyc));
    end

    // RUN with div {2,0}: 12 advance cycles
    do_reset();
    div_i = {8'd2, 8'd0};
    mode = 2'b01;
    n_adv = 0; n_ce0 = 0; n_ce1 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_adv += int'(advance); n_ce0 += int'(ce_o[0]); n_ce1 += int'(ce_o[1]);
    end
    tick();
    chk("run_adv", 64'(n_adv), 64'd12);
    chk("run_ce0", 64'(n_ce0), 64'd12);
    chk("run_ce1", 64'(n_ce1), 64'd4);
    chk("run_cyc", 64'(cyc_cnt), 64'd12);
    mode = 2'b00;
    tick(); tick();

    // BURST of 5
    do_reset();
    mode = 2'b11; burst_len = 8'd5; step_req = 1'b1;
    n_adv = 0; n_busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      step_req = 1'b0;
      n_adv += int'(advance); n_busy += int'(busy);
    end
    chk("burst5_adv", 64'(n_adv), 64'd5);
    chk("burst5_busy", 64'(n_busy), 64'd5);
    chk("burst5_cyc", 64'(cyc_cnt), 64'd5);

    // BURST abort with HALT sampled in the third burst cycle
    do_reset();
    mode = 2'b11; burst_len = 8'd10; step_req = 1'b1;
    n_adv = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); step_req = 1'b0; n_adv += int'(advance);
    end
    mode = 2'b00;
    for (int i = 0; i < 5; i++) begin tick(); n_adv += int'(advance); end
    chk("abort_adv", 64'(n_adv), 64'd3);
    chk("abort_cyc", 64'(cyc_cnt), 64'd3);

    // RUN requested mid-burst: burst finishes, then RUN
    do_reset();
    mode = 2'b11; burst_len = 8'd10; step_req = 1'b1;
    n_busy = 0;
    for (int i = 0; i < 14; i++) begin
      tick(); step_req = 1'b0;
      if (i == 2) mode = 2'b01;
      n_busy += int'(busy);
    end
    chk("burst_run_busy", 64'(n_busy), 64'd10);
    chk("burst_run_state", 64'({advance, busy}), 64'(2'b10));
    mode = 2'b00; tick();

    // Phase hold across HALT, then divisor change mid-period
    do_reset();
    div_i = {8'd0, 8'd3};
    mode = 2'b01; tick(); tick();
    mode = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    mode = 2'b01;
    mask = '0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (ce_o[0]) mask[i] = 1'b1;
      if (i == 4) div_i = {8'd0, 8'd1};
    end
    chk("phase_mask", 64'(mask), 64'h0A88);
    mode = 2'b00; tick();

    // Reset in the middle of a 20-cycle burst
    do_reset();
    div_i = {8'd1, 8'd0};
    mode = 2'b11; burst_len = 8'd20; step_req = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); step_req = 1'b0; end
    cyc0 = cyc_cnt;
    chk("rst_pre_cyc", 64'(cyc0), 64'd3);
    reset = 1'b1; tick();
    chk("rst_adv", 64'(advance), 64'd0);
    chk("rst_ce", 64'(ce_o), 64'd0);
    chk("rst_cyc", 64'(cyc_cnt), 64'd0);
    reset = 1'b0;
    n_adv = 0;
    for (int i = 0; i < 6; i++) begin tick(); n_adv += int'(advance); end
    chk("rst_no_resume", 64'(n_adv), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
